// File: rtl/data_mem_resp.sv
// Data-memory responder: answers req/gnt/rvalid load/store transactions from a
// word RAM plus flag/result status registers, with optional grant wait states.
module data_mem_resp #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] FLAG_ADDR   = 32'h0000_0400,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_0404,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] mem_flag_o,
  output logic [31:0] mem_result_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nx;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_cnt_nx;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_flag;
  logic [31:0]   r_result;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic          w_gnt;
  logic          w_ram_hit;
  logic          w_flag_hit;
  logic          w_result_hit;
  logic          w_miss;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_wr_word;
  logic          w_unused;

  assign w_unused = ^data_addr_i[1:0];

  assign w_gnt        = rst_ni && data_req_i && (r_wait_cnt == LP_WAIT);
  assign w_idx        = data_addr_i[AW+1:2];
  assign w_ram_hit    = (data_addr_i[31:AW+2] == '0);
  assign w_flag_hit   = !w_ram_hit && (data_addr_i[31:2] == FLAG_ADDR[31:2]);
  assign w_result_hit = !w_ram_hit && !w_flag_hit &&
                        (data_addr_i[31:2] == RESULT_ADDR[31:2]);
  assign w_miss       = !(w_ram_hit || w_flag_hit || w_result_hit);

  always_comb begin
    w_rd_word = '0;
    if (w_ram_hit)         w_rd_word = r_mem[w_idx];
    else if (w_flag_hit)   w_rd_word = r_flag;
    else if (w_result_hit) w_rd_word = r_result;
  end

  // Byte-lane merge of the write data over the currently stored word.
  always_comb begin
    w_wr_word = w_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (data_be_i[b]) w_wr_word[8*b +: 8] = data_wdata_i[8*b +: 8];
    end
  end

  // The wait counter only advances outside RESP, so after a grant the next
  // request always pays the full WAIT_CYCLES again plus the response cycle.
  always_comb begin
    w_state_nx    = r_state;
    w_wait_cnt_nx = r_wait_cnt;
    if (w_gnt) begin
      w_state_nx    = S_RESP;
      w_wait_cnt_nx = '0;
    end else if (r_state == S_RESP) begin
      w_state_nx    = S_IDLE;
      w_wait_cnt_nx = '0;
    end else if (data_req_i) begin
      w_state_nx    = S_WAIT;
      w_wait_cnt_nx = r_wait_cnt + 4'd1;
    end else begin
      w_state_nx    = S_IDLE;
      w_wait_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_flag     <= '0;
      r_result   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_wait_cnt <= w_wait_cnt_nx;
      r_rdata    <= (w_gnt && !data_we_i && !w_miss) ? w_rd_word : '0;
      r_err      <= w_gnt && w_miss;
      if (w_gnt && data_we_i && w_flag_hit)   r_flag   <= w_wr_word;
      if (w_gnt && data_we_i && w_result_hit) r_result <= w_wr_word;
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_gnt && data_we_i && w_ram_hit) r_mem[w_idx] <= w_wr_word;
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = (r_state == S_RESP);
  assign data_rdata_o  = r_rdata;
  assign data_err_o    = r_err;
  assign mem_flag_o    = r_flag;
  assign mem_result_o  = r_result;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: a zero-wait instance driven with directed
// and random back-to-back traffic against a word-level model, plus a 3-wait instance.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req0 = 1'b0, we0 = 1'b0, gnt0, rvalid0, err0;
  logic [31:0] addr0 = '0, wdata0 = '0, rdata0, flag0, result0;
  logic [3:0]  be0 = '0;

  logic        req3 = 1'b0, we3 = 1'b0, gnt3, rvalid3, err3;
  logic [31:0] addr3 = '0, wdata3 = '0, rdata3, flag3, result3;
  logic [3:0]  be3 = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl_mem [256];
  logic [31:0] mdl_flag = '0;
  logic [31:0] mdl_res  = '0;

  always #5 clk = ~clk;

  data_mem_resp #(.WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req0), .data_gnt_o(gnt0),
    .data_rvalid_o(rvalid0), .data_addr_i(addr0), .data_we_i(we0),
    .data_be_i(be0), .data_wdata_i(wdata0), .data_rdata_o(rdata0),
    .data_err_o(err0), .mem_flag_o(flag0), .mem_result_o(result0)
  );

  data_mem_resp #(.WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req3), .data_gnt_o(gnt3),
    .data_rvalid_o(rvalid3), .data_addr_i(addr3), .data_we_i(we3),
    .data_be_i(be3), .data_wdata_i(wdata3), .data_rdata_o(rdata3),
    .data_err_o(err3), .mem_flag_o(flag3), .mem_result_o(result3)
  );

  // Word-level model: apply one accepted transaction, return its response.
  task automatic model_op(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
    logic [31:0] cur;
    int kind;
    if (a < 32'd1024)              kind = 0;
    else if (a[31:2] == 30'h100)   kind = 1;
    else if (a[31:2] == 30'h101)   kind = 2;
    else                           kind = 3;
    rd = '0;
    er = (kind == 3);
    if (kind != 3) begin
      cur = (kind == 0) ? mdl_mem[a[9:2]] : (kind == 1) ? mdl_flag : mdl_res;
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
        if (kind == 0)      mdl_mem[a[9:2]] = cur;
        else if (kind == 1) mdl_flag = cur;
        else                mdl_res = cur;
      end else begin
        rd = cur;
      end
    end
  endtask

  // One cycle on a DUT: sample the response of the previous cycle, drive, sample grant.
  task automatic cycle0(input logic rq, input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, output logic g, output logic rv,
                        output logic [31:0] rd, output logic er, output logic [31:0] fl,
                        output logic [31:0] rs);
    @(negedge clk);
    rv = rvalid0; rd = rdata0; er = err0; fl = flag0; rs = result0;
    req0 = rq; addr0 = a; we0 = we; be0 = be; wdata0 = wd;
    #1 g = gnt0;
  endtask

  task automatic cycle3(input logic rq, input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, output logic g, output logic rv,
                        output logic [31:0] rd, output logic er, output logic [31:0] fl,
                        output logic [31:0] rs);
    @(negedge clk);
    rv = rvalid3; rd = rdata3; er = err3; fl = flag3; rs = result3;
    req3 = rq; addr3 = a; we3 = we; be3 = be; wdata3 = wd;
    #1 g = gnt3;
  endtask

  task automatic test_reset;
    #2 req0 = 1'b1; req3 = 1'b1;
    #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_gnt: got %b want 0", gnt0); end
    checks++; if (rvalid0 !== 1'b0 || rvalid3 !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid: got %b/%b want 0/0", rvalid0, rvalid3); end
    checks++; if (rdata0 !== 32'h0 || err0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_rdata_err: got %h/%b want 0/0", rdata0, err0); end
    checks++; if (flag0 !== 32'h0 || result0 !== 32'h0) begin errors++; $display("[TB] FAIL rst_status: got %h/%h want 0/0", flag0, result0); end
    req0 = 1'b0; req3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_rw;
    logic g, rv, er, eer; logic [31:0] rd, fl, rs, erd;
    cycle0(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, g, rv, rd, er, fl, rs);
    checks++; if (g !== 1'b1) begin errors++; $display("[TB] FAIL basic_wr_gnt: got %b want 1", g); end
    model_op(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, erd, eer);
    cycle0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b1 || rd !== 32'h0 || er !== 1'b0) begin errors++; $display("[TB] FAIL basic_wr_resp: got rv=%b rd=%h err=%b want 1/0/0", rv, rd, er); end
    cycle0(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (g !== 1'b1 || rv !== 1'b0) begin errors++; $display("[TB] FAIL basic_rd_gnt: got gnt=%b rv=%b want 1/0", g, rv); end
    model_op(32'h10, 1'b0, 4'h0, 32'h0, erd, eer);
    cycle0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("[TB] FAIL basic_rd_resp: got rv=%b rd=%h err=%b want 1/deadbeef/0", rv, rd, er); end
    cycle0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b0 || rd !== 32'h0 || er !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got rv=%b rd=%h err=%b want 0/0/0", rv, rd, er); end
  endtask

  task automatic test_partial_write;
    logic g, rv, er, eer; logic [31:0] rd, fl, rs, erd;
    cycle0(1'b1, 32'h20, 1'b1, 4'hF, 32'h11223344, g, rv, rd, er, fl, rs);
    model_op(32'h20, 1'b1, 4'hF, 32'h11223344, erd, eer);
    cycle0(1'b1, 32'h22, 1'b1, 4'b0010, 32'h0000AB00, g, rv, rd, er, fl, rs);
    model_op(32'h22, 1'b1, 4'b0010, 32'h0000AB00, erd, eer);
    cycle0(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    model_op(32'h20, 1'b0, 4'h0, 32'h0, erd, eer);
    cycle0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b1 || rd !== 32'h1122AB44 || rd !== erd) begin errors++; $display("[TB] FAIL partial_rd: got rv=%b rd=%h want 1/1122ab44", rv, rd); end
  endtask

  task automatic test_status_regs;
    logic g, rv, er, eer; logic [31:0] rd, fl, rs, erd;
    cycle0(1'b1, 32'h404, 1'b1, 4'hF, 32'd55, g, rv, rd, er, fl, rs);
    model_op(32'h404, 1'b1, 4'hF, 32'd55, erd, eer);
    cycle0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rs !== 32'd55 || fl !== 32'd0) begin errors++; $display("[TB] FAIL status_result: got res=%0d flag=%0d want 55/0", rs, fl); end
    cycle0(1'b1, 32'h400, 1'b1, 4'hF, 32'd1, g, rv, rd, er, fl, rs);
    model_op(32'h400, 1'b1, 4'hF, 32'd1, erd, eer);
    cycle0(1'b1, 32'h404, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (fl !== 32'd1) begin errors++; $display("[TB] FAIL status_flag: got %0d want 1", fl); end
    model_op(32'h404, 1'b0, 4'h0, 32'h0, erd, eer);
    cycle0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b1 || rd !== 32'd55 || er !== 1'b0) begin errors++; $display("[TB] FAIL status_readback: got rv=%b rd=%0d err=%b want 1/55/0", rv, rd, er); end
  endtask

  task automatic test_error;
    logic g, rv, er, eer; logic [31:0] rd, fl, rs, erd;
    cycle0(1'b1, 32'h2000, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    model_op(32'h2000, 1'b0, 4'h0, 32'h0, erd, eer);
    cycle0(1'b1, 32'h800, 1'b1, 4'hF, 32'hFFFFFFFF, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL err_read: got rv=%b err=%b rd=%h want 1/1/0", rv, er, rd); end
    model_op(32'h800, 1'b1, 4'hF, 32'hFFFFFFFF, erd, eer);
    cycle0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL err_write: got rv=%b err=%b rd=%h want 1/1/0", rv, er, rd); end
    checks++; if (fl !== 32'd1 || rs !== 32'd55) begin errors++; $display("[TB] FAIL err_no_change: got flag=%h res=%h want 1/37", fl, rs); end
  endtask

  // Random traffic with req often held for consecutive grants.
  task automatic test_random_b2b;
    logic g, rv, er, rq, we, pv, perr; logic [3:0] be;
    logic [31:0] a, wd, rd, fl, rs, prd;
    pv = 1'b0; prd = '0; perr = 1'b0;
    for (int k = 0; k < 61; k++) begin
      rq = (k < 16) ? 1'b1 : (k == 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (k < 16) begin
        a = 32'((64 + k) * 4); we = 1'b1; be = 4'hF; wd = $urandom;
      end else begin
        case ($urandom_range(0, 5))
          0, 1, 2: a = 32'((64 + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3));
          3:       a = 32'h400;
          4:       a = 32'h404;
          default: a = ($urandom_range(0, 1) != 0) ? 32'(32'h800 + 4 * $urandom_range(0, 63))
                                                  : ($urandom | 32'h8000_0000);
        endcase
        we = 1'($urandom_range(0, 1)); be = 4'($urandom_range(0, 15)); wd = $urandom;
      end
      cycle0(rq, a, we, be, wd, g, rv, rd, er, fl, rs);
      checks++; if (g !== rq) begin errors++; $display("[TB] FAIL rnd_gnt[%0d]: got %b want %b", k, g, rq); end
      checks++; if (rv !== pv) begin errors++; $display("[TB] FAIL rnd_rvalid[%0d]: got %b want %b", k, rv, pv); end
      checks++; if (rd !== (pv ? prd : 32'h0) || er !== (pv ? perr : 1'b0)) begin errors++; $display("[TB] FAIL rnd_resp[%0d]: got rd=%h err=%b want %h/%b", k, rd, er, pv ? prd : 32'h0, pv & perr); end
      checks++; if (fl !== mdl_flag || rs !== mdl_res) begin errors++; $display("[TB] FAIL rnd_status[%0d]: got %h/%h want %h/%h", k, fl, rs, mdl_flag, mdl_res); end
      if (rq) model_op(a, we, be, wd, prd, perr);
      pv = rq;
    end
  endtask

  task automatic test_wait3;
    logic g, rv, er, rq, eg, erv; logic [31:0] rd, fl, rs, val;
    val = $urandom;
    // Two back-to-back requests with req held: grants on cycles 3 and 8.
    for (int k = 0; k <= 10; k++) begin
      rq = (k <= 8);
      if (k <= 3) cycle3(rq, 32'h404, 1'b1, 4'hF, val, g, rv, rd, er, fl, rs);
      else        cycle3(rq, 32'h404, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
      eg = (k == 3 || k == 8); erv = (k == 4 || k == 9);
      checks++; if (g !== eg) begin errors++; $display("[TB] FAIL w3_gnt[%0d]: got %b want %b", k, g, eg); end
      checks++; if (rv !== erv) begin errors++; $display("[TB] FAIL w3_rvalid[%0d]: got %b want %b", k, rv, erv); end
      if (k == 4) begin
        checks++; if (rs !== val || rd !== 32'h0) begin errors++; $display("[TB] FAIL w3_write: got res=%h rd=%h want %h/0", rs, rd, val); end
      end
      if (k == 9) begin
        checks++; if (rd !== val || er !== 1'b0) begin errors++; $display("[TB] FAIL w3_read: got rd=%h err=%b want %h/0", rd, er, val); end
      end
    end
    // Request dropped after 2 cycles, then re-raised: full wait again.
    for (int k = 0; k <= 8; k++) begin
      rq = (k < 2) || (k >= 3 && k <= 6);
      cycle3(rq, 32'h404, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
      eg = (k == 6); erv = (k == 7);
      checks++; if (g !== eg) begin errors++; $display("[TB] FAIL w3_drop_gnt[%0d]: got %b want %b", k, g, eg); end
      checks++; if (rv !== erv) begin errors++; $display("[TB] FAIL w3_drop_rvalid[%0d]: got %b want %b", k, rv, erv); end
      if (k == 7) begin
        checks++; if (rd !== val) begin errors++; $display("[TB] FAIL w3_drop_read: got %h want %h", rd, val); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic g, rv, er, eer; logic [31:0] rd, fl, rs, erd;
    cycle0(1'b1, 32'h400, 1'b1, 4'hF, 32'd7, g, rv, rd, er, fl, rs);
    checks++; if (g !== 1'b1) begin errors++; $display("[TB] FAIL rmid_gnt: got %b want 1", g); end
    @(posedge clk);
    #1 rst_n = 1'b0; req0 = 1'b0;
    mdl_flag = '0; mdl_res = '0;
    #1;
    checks++; if (rvalid0 !== 1'b0 || flag0 !== 32'h0 || result0 !== 32'h0) begin errors++; $display("[TB] FAIL rmid_async: got rv=%b flag=%h res=%h want 0/0/0", rvalid0, flag0, result0); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle0(1'b1, 32'h404, 1'b1, 4'hF, 32'd9, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b0 || g !== 1'b1 || fl !== 32'h0) begin errors++; $display("[TB] FAIL rmid_after: got rv=%b gnt=%b flag=%h want 0/1/0", rv, g, fl); end
    model_op(32'h404, 1'b1, 4'hF, 32'd9, erd, eer);
    cycle0(1'b1, 32'h404, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b1 || rs !== mdl_res) begin errors++; $display("[TB] FAIL rmid_wr: got rv=%b res=%h want 1/%h", rv, rs, mdl_res); end
    model_op(32'h404, 1'b0, 4'h0, 32'h0, erd, eer);
    cycle0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, rv, rd, er, fl, rs);
    checks++; if (rv !== 1'b1 || rd !== 32'd9 || rd !== erd) begin errors++; $display("[TB] FAIL rmid_rd: got rv=%b rd=%h want 1/9", rv, rd); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_partial_write();
    test_status_regs();
    test_error();
    test_random_b2b();
    test_wait3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
